// File: rtl/nrf24_spi_master.sv
// nRF24L01 SPI mode-0 byte master: one CSN-low window per start, command byte plus payload.
// SCK is derived from clk_50 by a half-period divider; all pins are registered.
module nrf24_spi_master #(
    parameter int CLK_DIV = 3,
    parameter int MAX_LEN = 33
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_csn
);
    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [5:0]    LEN_MAX  = 6'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, CSN_SETUP, LOAD, SHIFT, CSN_HOLD, GAP} state_t;
    state_t state, state_next;

    logic [DW-1:0] div_cnt, div_cnt_d, div_next;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [5:0]    byte_cnt, byte_cnt_d;
    logic [7:0]    tx_shift, tx_shift_d;
    logic [7:0]    rx_shift, rx_shift_d;
    logic [7:0]    rx_data_d;
    logic          gap_half, gap_half_d;
    logic          tx_ready_d, rx_valid_d, busy_d, done_d, sck_d, mosi_d, csn_d;
    logic          div_last, accept, handshake, sck_rise, sck_fall, byte_end, more_bytes;
    logic [5:0]    len_clamped;

    assign div_last    = (div_cnt == DIV_LAST);
    assign div_next    = div_last ? '0 : div_cnt + DW'(1);
    assign accept      = start && (len != 6'd0);
    assign handshake   = (state == LOAD) && tx_valid && tx_ready;
    assign sck_rise    = (state == SHIFT) && !spi_sck && div_last;
    assign sck_fall    = (state == SHIFT) && spi_sck && div_last;
    assign byte_end    = sck_fall && (bit_cnt == 3'd7);
    assign more_bytes  = (byte_cnt != 6'd1);
    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept)                state_next = CSN_SETUP;
            CSN_SETUP: if (div_last)              state_next = LOAD;
            LOAD:      if (handshake)             state_next = SHIFT;
            SHIFT:     if (byte_end)              state_next = more_bytes ? LOAD : CSN_HOLD;
            CSN_HOLD:  if (div_last)              state_next = GAP;
            GAP:       if (div_last && gap_half)  state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    // Next values of every registered output and datapath register.
    always_comb begin
        div_cnt_d  = '0;
        bit_cnt_d  = bit_cnt;
        byte_cnt_d = byte_cnt;
        tx_shift_d = tx_shift;
        rx_shift_d = rx_shift;
        rx_data_d  = rx_data;
        gap_half_d = gap_half;
        tx_ready_d = tx_ready;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy;
        sck_d      = spi_sck;
        mosi_d     = spi_mosi;
        csn_d      = spi_csn;
        case (state)
            IDLE: begin
                if (accept) begin
                    csn_d      = 1'b0;
                    busy_d     = 1'b1;
                    byte_cnt_d = len_clamped;
                end
            end
            CSN_SETUP: begin
                div_cnt_d = div_next;
                if (div_last) tx_ready_d = 1'b1;
            end
            LOAD: begin
                if (handshake) begin
                    tx_ready_d = 1'b0;
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[7];
                    bit_cnt_d  = 3'd0;
                end
            end
            SHIFT: begin
                div_cnt_d = div_next;
                if (sck_rise) begin
                    sck_d      = 1'b1;
                    rx_shift_d = {rx_shift[6:0], spi_miso};
                end else if (sck_fall) begin
                    sck_d = 1'b0;
                    // Last fall closes the byte; the next byte's request overlaps rx_valid.
                    if (bit_cnt == 3'd7) begin
                        rx_data_d  = rx_shift;
                        rx_valid_d = 1'b1;
                        byte_cnt_d = byte_cnt - 6'd1;
                        mosi_d     = 1'b0;
                        tx_ready_d = more_bytes;
                    end else begin
                        bit_cnt_d  = bit_cnt + 3'd1;
                        mosi_d     = tx_shift[6];
                        tx_shift_d = {tx_shift[6:0], 1'b0};
                    end
                end
            end
            CSN_HOLD: begin
                div_cnt_d = div_next;
                if (div_last) begin
                    csn_d      = 1'b1;
                    gap_half_d = 1'b0;
                end
            end
            GAP: begin
                div_cnt_d = div_next;
                if (div_last) begin
                    gap_half_d = 1'b1;
                    if (gap_half) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 6'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            gap_half <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_csn  <= 1'b1;
        end else begin
            div_cnt  <= div_cnt_d;
            bit_cnt  <= bit_cnt_d;
            byte_cnt <= byte_cnt_d;
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            rx_data  <= rx_data_d;
            gap_half <= gap_half_d;
            tx_ready <= tx_ready_d;
            rx_valid <= rx_valid_d;
            busy     <= busy_d;
            done     <= done_d;
            spi_sck  <= sck_d;
            spi_mosi <= mosi_d;
            spi_csn  <= csn_d;
        end
    end
endmodule

// File: tb/tb_nrf24_spi_master.sv
// Bench for nrf24_spi_master: two instances (CLK_DIV=3 and CLK_DIV=2) sharing one mode-0 slave model.
// Expected MOSI and rx bytes are queued when a transaction is driven and popped as the DUT produces them.
module tb_nrf24_spi_master;
    logic       clk = 1'b0;
    logic       rst_n, start, tx_valid, miso, sel;
    logic [5:0] len;
    logic [7:0] tx_data;

    logic       tx_ready_a, rx_valid_a, busy_a, done_a, sck_a, mosi_a, csn_a;
    logic       tx_ready_b, rx_valid_b, busy_b, done_b, sck_b, mosi_b, csn_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       tx_ready_m, rx_valid_m, busy_m, done_m, sck_m, mosi_m, csn_m;
    logic [7:0] rx_data_m;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_mosi[$];
    logic [7:0] miso_q[$];
    logic [7:0] tx_bytes[64];
    logic [7:0] miso_bytes[64];

    int rises, rxv, csn_falls, dones, sck_high, per_min, setup_cyc, viol;
    int csn_fall_cyc, csn_rise_cyc, last_rise_cyc, done_cyc;
    logic prev_csn = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;

    int         s_bits = 0;
    logic [7:0] s_in = 8'h00, s_out = 8'h00;

    typedef struct {
        bit              div2;
        logic [5:0]      len;
        int              nbytes;
        int              exp_rises;
        logic [0:5][7:0] tx;
        logic [0:5][7:0] rx;
        int              stall_byte;
        int              stall_cyc;
        bit              poke;
    } vec_t;
    vec_t vecs[7];

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    nrf24_spi_master #(.CLK_DIV(3), .MAX_LEN(33)) dut_a (
        .clk_50(clk), .rst_n(rst_n), .start(start & ~sel), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid & ~sel), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a), .done(done_a),
        .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso), .spi_csn(csn_a)
    );

    nrf24_spi_master #(.CLK_DIV(2), .MAX_LEN(33)) dut_b (
        .clk_50(clk), .rst_n(rst_n), .start(start & sel), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid & sel), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b), .done(done_b),
        .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso), .spi_csn(csn_b)
    );

    assign tx_ready_m = sel ? tx_ready_b : tx_ready_a;
    assign rx_valid_m = sel ? rx_valid_b : rx_valid_a;
    assign rx_data_m  = sel ? rx_data_b  : rx_data_a;
    assign busy_m     = sel ? busy_b     : busy_a;
    assign done_m     = sel ? done_b     : done_a;
    assign sck_m      = sel ? sck_b      : sck_a;
    assign mosi_m     = sel ? mosi_b     : mosi_a;
    assign csn_m      = sel ? csn_b      : csn_a;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reset_stats();
        rises = 0; rxv = 0; csn_falls = 0; dones = 0; sck_high = 0; viol = 0;
        per_min = 9999; setup_cyc = -1;
        csn_fall_cyc = 0; csn_rise_cyc = 0; last_rise_cyc = 0; done_cyc = 0;
    endtask

    // Pin monitor: framing counters, protocol violations and the rx scoreboard.
    always @(negedge clk) begin
        if (prev_csn && !csn_m) begin csn_falls++; csn_fall_cyc = cyc; end
        if (!prev_csn && csn_m) csn_rise_cyc = cyc;
        if (!prev_sck && sck_m) begin
            rises++;
            if (rises == 1) setup_cyc = cyc - csn_fall_cyc;
            else if (cyc - last_rise_cyc < per_min) per_min = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
        end
        if (sck_m) sck_high++;
        if (done_m) begin dones++; done_cyc = cyc; end
        if ((sck_m && csn_m) || (csn_m && mosi_m) || (sck_m && (mosi_m !== prev_mosi))) viol++;
        if (rx_valid_m) begin
            rxv++;
            if (exp_rx.size() == 0) check_output("rx_valid unexpected", 64'd1, 64'd0);
            else check_output("rx_data", {56'd0, rx_data_m}, {56'd0, exp_rx.pop_front()});
        end
        prev_csn  = csn_m;
        prev_sck  = sck_m;
        prev_mosi = mosi_m;
    end

    // Mode-0 slave: MISO changes on CSN fall and SCK fall, MOSI captured on SCK rise.
    always @(negedge csn_m) begin
        s_bits = 0;
        if (miso_q.size() > 0) s_out = miso_q.pop_front();
        else s_out = 8'h00;
        miso = s_out[7];
    end

    always @(posedge csn_m) begin
        s_bits = 0;
        miso   = 1'b0;
    end

    always @(posedge sck_m) begin
        s_in = {s_in[6:0], mosi_m};
        s_bits++;
        if (s_bits == 8) begin
            s_bits = 0;
            if (exp_mosi.size() == 0) check_output("mosi unexpected", 64'd1, 64'd0);
            else check_output("mosi byte", {56'd0, s_in}, {56'd0, exp_mosi.pop_front()});
        end
    end

    always @(negedge sck_m) begin
        if (s_bits == 0) begin
            if (miso_q.size() > 0) s_out = miso_q.pop_front();
            else s_out = 8'h00;
        end else begin
            s_out = {s_out[6:0], 1'b0};
        end
        miso = s_out[7];
    end

    task automatic apply_stimulus(input bit d2, input logic [5:0] l, input int nb, input int exp_rises,
                                  input int stall_b, input int stall_c, input bit poke, input string tag);
        int div, to, bad;
        div = d2 ? 2 : 3;
        @(posedge clk);
        sel = d2;
        reset_stats();
        for (int i = 0; i < nb; i++) begin
            exp_mosi.push_back(tx_bytes[i]);
            exp_rx.push_back(miso_bytes[i]);
            miso_q.push_back(miso_bytes[i]);
        end
        @(negedge clk); start = 1'b1; len = l;
        @(negedge clk); start = 1'b0; len = 6'd0;
        for (int i = 0; i < nb; i++) begin
            to = 0;
            while (!tx_ready_m && to < 200) begin @(negedge clk); to++; end
            if (!tx_ready_m) begin
                check_output({tag, " tx_ready timeout"}, 64'd0, 64'd1);
                break;
            end
            if (i == stall_b) begin
                bad = 0;
                repeat (stall_c) begin
                    @(negedge clk);
                    if (sck_m || csn_m || !busy_m || !tx_ready_m) bad++;
                end
                check_output({tag, " stall pins"}, 64'(bad), 64'd0);
            end
            tx_data = tx_bytes[i]; tx_valid = 1'b1;
            @(negedge clk); tx_valid = 1'b0; tx_data = 8'h00;
            if (poke && i == 0) begin
                start = 1'b1; len = 6'd1;
                @(negedge clk); start = 1'b0; len = 6'd0;
            end
        end
        to = 0;
        while (!done_m && to < 3000) begin @(negedge clk); to++; end
        check_output({tag, " done seen"}, {63'd0, done_m}, 64'd1);
        repeat (3) @(negedge clk);
        check_output({tag, " sck rises"}, 64'(rises), 64'(exp_rises));
        check_output({tag, " rx_valid pulses"}, 64'(rxv), 64'(nb));
        check_output({tag, " csn windows"}, 64'(csn_falls), 64'd1);
        check_output({tag, " done pulses"}, 64'(dones), 64'd1);
        check_output({tag, " sck high cycles"}, 64'(sck_high), 64'(8 * nb * div));
        check_output({tag, " sck period"}, 64'(per_min), 64'(2 * div));
        check_output({tag, " csn setup"}, {63'd0, setup_cyc >= div}, 64'd1);
        check_output({tag, " csn gap"}, {63'd0, (done_cyc - csn_rise_cyc) >= 2 * div}, 64'd1);
        check_output({tag, " pin violations"}, 64'(viol), 64'd0);
        check_output({tag, " leftover bytes"}, 64'(exp_rx.size() + exp_mosi.size()), 64'd0);
        check_output({tag, " idle pins"}, {61'd0, busy_m, csn_m, tx_ready_m}, 64'b010);
        exp_rx.delete(); exp_mosi.delete(); miso_q.delete();
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int to;
        rst_n = 1'b0; start = 1'b0; len = 6'd0; tx_data = 8'h00; tx_valid = 1'b0; miso = 1'b0; sel = 1'b0;

        vecs[0] = '{1'b0, 6'd1, 1, 8,  {8'hFF, 40'h0}, {8'h0E, 40'h0}, 99, 0, 1'b0};
        vecs[1] = '{1'b0, 6'd6, 6, 48, {8'h30, 8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'hE7},
                                       {8'h0E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 99, 0, 1'b0};
        vecs[2] = '{1'b0, 6'd3, 3, 24, {8'hA5, 8'h5A, 8'hC3, 24'h0}, {8'h0E, 8'h81, 8'h7E, 24'h0}, 1, 20, 1'b0};
        vecs[3] = '{1'b0, 6'd2, 2, 16, {8'h20, 8'h3F, 32'h0}, {8'h0E, 8'h96, 32'h0}, 99, 0, 1'b1};
        vecs[4] = '{1'b1, 6'd2, 2, 16, {8'h61, 8'h00, 32'h0}, {8'h0E, 8'hA5, 32'h0}, 99, 0, 1'b0};
        vecs[5] = '{1'b1, 6'd4, 4, 32, {8'h01, 8'h80, 8'hFF, 8'h00, 16'h0},
                                       {8'h0E, 8'h01, 8'h80, 8'hF0, 16'h0}, 3, 5, 1'b0};
        vecs[6] = '{1'b1, 6'd1, 1, 8,  {8'h55, 40'h0}, {8'hAA, 40'h0}, 99, 0, 1'b0};

        repeat (3) @(negedge clk);
        check_output("reset pins a", {49'd0, csn_a, sck_a, mosi_a, tx_ready_a, rx_data_a, rx_valid_a, busy_a, done_a},
                     64'h4000);
        check_output("reset pins b", {49'd0, csn_b, sck_b, mosi_b, tx_ready_b, rx_data_b, rx_valid_b, busy_b, done_b},
                     64'h4000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        reset_stats();
        start = 1'b1; len = 6'd0;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        check_output("len0 csn activity", 64'(csn_falls), 64'd0);
        check_output("len0 busy", {63'd0, busy_m}, 64'd0);

        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < vecs[k].nbytes; i++) begin
                tx_bytes[i]   = vecs[k].tx[i];
                miso_bytes[i] = vecs[k].rx[i];
            end
            apply_stimulus(vecs[k].div2, vecs[k].len, vecs[k].nbytes, vecs[k].exp_rises,
                           vecs[k].stall_byte, vecs[k].stall_cyc, vecs[k].poke, $sformatf("vec%0d", k));
        end

        // Abort mid-SHIFT: outputs return to reset values immediately, no done or rx_valid afterwards.
        @(posedge clk);
        sel = 1'b0;
        reset_stats();
        miso_q.push_back(8'h0E);
        @(negedge clk); start = 1'b1; len = 6'd2;
        @(negedge clk); start = 1'b0; len = 6'd0;
        to = 0;
        while (!tx_ready_m && to < 200) begin @(negedge clk); to++; end
        tx_data = 8'hC3; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0; tx_data = 8'h00;
        to = 0;
        while (!(sck_m && rises >= 3) && to < 200) begin @(negedge clk); to++; end
        check_output("abort reached shift", {63'd0, sck_m}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_output("abort pins a", {49'd0, csn_a, sck_a, mosi_a, tx_ready_a, rx_data_a, rx_valid_a, busy_a, done_a},
                     64'h4000);
        check_output("abort pins b", {49'd0, csn_b, sck_b, mosi_b, tx_ready_b, rx_data_b, rx_valid_b, busy_b, done_b},
                     64'h4000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_output("abort done pulses", 64'(dones), 64'd0);
        check_output("abort rx_valid pulses", 64'(rxv), 64'd0);
        check_output("abort csn idle", {63'd0, csn_m}, 64'd1);
        exp_rx.delete(); exp_mosi.delete(); miso_q.delete();

        // Oversized len clamps to 33 bytes.
        for (int i = 0; i < 33; i++) begin
            tx_bytes[i]   = 8'(i * 7 + 3);
            miso_bytes[i] = 8'(255 - i);
        end
        apply_stimulus(1'b0, 6'd40, 33, 264, 99, 0, 1'b0, "clamp");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
